// File: rtl/bcd_timer_if.sv
// bcd_countdown_timer control/display bundle.
// master drives controls + load digits; slave drives time digits + status.
interface bcd_timer_if #(
  parameter int BCD_W = 4
);
  logic             i_tick;
  logic             i_clear;
  logic             i_load_en;
  logic             i_start;
  logic             i_pause;
  logic [BCD_W-1:0] i_load_sec0;
  logic [BCD_W-1:0] i_load_sec1;
  logic [BCD_W-1:0] i_load_min0;
  logic [BCD_W-1:0] i_load_min1;
  logic [BCD_W-1:0] i_load_hour0;
  logic [BCD_W-1:0] i_load_hour1;
  logic [BCD_W-1:0] o_sec0;
  logic [BCD_W-1:0] o_sec1;
  logic [BCD_W-1:0] o_min0;
  logic [BCD_W-1:0] o_min1;
  logic [BCD_W-1:0] o_hour0;
  logic [BCD_W-1:0] o_hour1;
  logic             o_running;
  logic             o_paused;
  logic             o_done;
  logic             o_load_err;

  modport master (
    output i_tick, i_clear, i_load_en,
    output i_start, i_pause,
    output i_load_sec0, i_load_sec1,
    output i_load_min0, i_load_min1,
    output i_load_hour0, i_load_hour1,
    input  o_sec0, o_sec1, o_min0,
    input  o_min1, o_hour0, o_hour1,
    input  o_running, o_paused,
    input  o_done, o_load_err
  );

  modport slave (
    input  i_tick, i_clear, i_load_en,
    input  i_start, i_pause,
    input  i_load_sec0, i_load_sec1,
    input  i_load_min0, i_load_min1,
    input  i_load_hour0, i_load_hour1,
    output o_sec0, o_sec1, o_min0,
    output o_min1, o_hour0, o_hour1,
    output o_running, o_paused,
    output o_done, o_load_err
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// hh:mm:ss BCD countdown timer: load, 1 Hz decrement with borrow, expiry.
// Ports: i_clk, i_rst (async high), bus (bcd_timer_if.slave).
module bcd_countdown_timer #(
  parameter int BCD_W     = 4,
  parameter int HOUR1_MAX = 2
) (
  input logic        i_clk,
  input logic        i_rst,
  bcd_timer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, RUN, PAUSE, DONE
  } state_t;

  localparam logic [BCD_W-1:0] C0 = '0;
  localparam logic [BCD_W-1:0] C1 = BCD_W'(1);
  localparam logic [BCD_W-1:0] C3 = BCD_W'(3);
  localparam logic [BCD_W-1:0] C5 = BCD_W'(5);
  localparam logic [BCD_W-1:0] C9 = BCD_W'(9);
  localparam logic [BCD_W-1:0] CH = BCD_W'(HOUR1_MAX);

  state_t           r_state;
  logic [BCD_W-1:0] r_s0, r_s1, r_m0;
  logic [BCD_W-1:0] r_m1, r_h0, r_h1;
  logic             r_running;
  logic             r_paused;
  logic             r_done;
  logic             r_load_err;

  logic             w_b0, w_b1, w_b2, w_b3, w_b4;
  logic [BCD_W-1:0] w_s0, w_s1, w_m0;
  logic [BCD_W-1:0] w_m1, w_h0, w_h1;
  logic             w_zero, w_one, w_legal;
  logic             w_idle_like;

  // borrow ripples up only while every lower digit sits at zero
  assign w_b0 = (r_s0 == C0);
  assign w_b1 = w_b0 & (r_s1 == C0);
  assign w_b2 = w_b1 & (r_m0 == C0);
  assign w_b3 = w_b2 & (r_m1 == C0);
  assign w_b4 = w_b3 & (r_h0 == C0);

  assign w_s0 = w_b0 ? C9 : r_s0 - C1;
  assign w_s1 = !w_b0 ? r_s1 :
                w_b1 ? C5 : r_s1 - C1;
  assign w_m0 = !w_b1 ? r_m0 :
                w_b2 ? C9 : r_m0 - C1;
  assign w_m1 = !w_b2 ? r_m1 :
                w_b3 ? C5 : r_m1 - C1;
  assign w_h0 = !w_b3 ? r_h0 :
                w_b4 ? C9 : r_h0 - C1;
  assign w_h1 = !w_b4 ? r_h1 : r_h1 - C1;

  assign w_zero = w_b4 & (r_h1 == C0);
  assign w_one  = (r_s0 == C1) & (r_s1 == C0) &
                  (r_m0 == C0) & (r_m1 == C0) &
                  (r_h0 == C0) & (r_h1 == C0);

  assign w_legal =
    (bus.i_load_sec0  <= C9) &
    (bus.i_load_sec1  <= C5) &
    (bus.i_load_min0  <= C9) &
    (bus.i_load_min1  <= C5) &
    (bus.i_load_hour0 <= C9) &
    (bus.i_load_hour1 <= CH) &
    ((bus.i_load_hour1 != CH) |
     (bus.i_load_hour0 <= C3));

  assign w_idle_like = (r_state == IDLE) |
                       (r_state == PAUSE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_s0       <= C0;
      r_s1       <= C0;
      r_m0       <= C0;
      r_m1       <= C0;
      r_h0       <= C0;
      r_h1       <= C0;
      r_running  <= 1'b0;
      r_paused   <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
      if (bus.i_clear) begin
        r_state   <= IDLE;
        r_s0      <= C0;
        r_s1      <= C0;
        r_m0      <= C0;
        r_m1      <= C0;
        r_h0      <= C0;
        r_h1      <= C0;
        r_running <= 1'b0;
        r_paused  <= 1'b0;
      end else if (bus.i_load_en) begin
        if (r_state != RUN && w_legal) begin
          r_state   <= IDLE;
          r_s0      <= bus.i_load_sec0;
          r_s1      <= bus.i_load_sec1;
          r_m0      <= bus.i_load_min0;
          r_m1      <= bus.i_load_min1;
          r_h0      <= bus.i_load_hour0;
          r_h1      <= bus.i_load_hour1;
          r_running <= 1'b0;
          r_paused  <= 1'b0;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (bus.i_pause) begin
        if (r_state == RUN) begin
          r_state   <= PAUSE;
          r_running <= 1'b0;
          r_paused  <= 1'b1;
        end
      end else if (bus.i_start) begin
        // a tick in the same cycle is dropped
        if (w_idle_like && !w_zero) begin
          r_state   <= RUN;
          r_running <= 1'b1;
          r_paused  <= 1'b0;
        end
      end else if (bus.i_tick && r_state == RUN) begin
        r_s0 <= w_s0;
        r_s1 <= w_s1;
        r_m0 <= w_m0;
        r_m1 <= w_m1;
        r_h0 <= w_h0;
        r_h1 <= w_h1;
        if (w_one) begin
          r_state   <= DONE;
          r_running <= 1'b0;
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign bus.o_sec0     = r_s0;
  assign bus.o_sec1     = r_s1;
  assign bus.o_min0     = r_m0;
  assign bus.o_min1     = r_m1;
  assign bus.o_hour0    = r_h0;
  assign bus.o_hour1    = r_h1;
  assign bus.o_running  = r_running;
  assign bus.o_paused   = r_paused;
  assign bus.o_done     = r_done;
  assign bus.o_load_err = r_load_err;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed scoreboard bench for bcd_countdown_timer.
// Flags nibble is {running, paused, done, load_err}.
module tb_bcd_countdown_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_timer_if #(.BCD_W(4)) bus ();

  bcd_countdown_timer #(
    .BCD_W(4),
    .HOUR1_MAX(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    string       tag;
    logic [27:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] TK = 5'b10000;
  localparam logic [4:0] CL = 5'b01000;
  localparam logic [4:0] LD = 5'b00100;
  localparam logic [4:0] ST = 5'b00010;
  localparam logic [4:0] PS = 5'b00001;

  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_RUN  = 4'b1000;
  localparam logic [3:0] F_PAU  = 4'b0100;
  localparam logic [3:0] F_DONE = 4'b0010;
  localparam logic [3:0] F_ERR  = 4'b0001;

  logic [27:0] obs;
  assign obs = {bus.o_hour1, bus.o_hour0,
                bus.o_min1, bus.o_min0,
                bus.o_sec1, bus.o_sec0,
                bus.o_running, bus.o_paused,
                bus.o_done, bus.o_load_err};

  function automatic logic [23:0] to_bcd(int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10),
            4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic drive(input logic [4:0] c,
                       input logic [23:0] v);
    {bus.i_tick, bus.i_clear, bus.i_load_en,
     bus.i_start, bus.i_pause} = c;
    {bus.i_load_hour1, bus.i_load_hour0,
     bus.i_load_min1, bus.i_load_min0,
     bus.i_load_sec1, bus.i_load_sec0} = v;
  endtask

  task automatic check();
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect_now(input string tag,
                            input logic [23:0] d,
                            input logic [3:0] f);
    sb.push_back('{tag, {d, f}});
  endtask

  // one clock: drive at negedge, result checked next negedge
  task automatic step(input string tag,
                      input logic [4:0] c,
                      input logic [23:0] v,
                      input logic [23:0] d,
                      input logic [3:0] f);
    drive(c, v);
    expect_now(tag, d, f);
    @(posedge clk);
    #1 drive(NO, 24'h0);
    @(negedge clk);
    check();
  endtask

  initial begin
    drive(NO, 24'h0);
    repeat (2) @(negedge clk);
    expect_now("reset", 24'h000000, F_IDLE);
    check();
    rst = 1'b0;
    @(negedge clk);

    // 1: one minute countdown to expiry
    step("t1_load", LD, 24'h000100, 24'h000100, F_IDLE);
    step("t1_start", ST, 0, 24'h000100, F_RUN);
    for (int i = 1; i <= 60; i++) begin
      step($sformatf("t1_tick%0d", i), TK, 0,
           to_bcd(60 - i),
           (i == 60) ? F_DONE : F_RUN);
    end
    step("t1_done_gone", NO, 0, 24'h000000, F_IDLE);
    step("t1_tick_in_done", TK, 0, 24'h000000, F_IDLE);
    step("t1_start_zero", ST, 0, 24'h000000, F_IDLE);

    // 2: full borrow chain
    step("t2_load", LD, 24'h100000, 24'h100000, F_IDLE);
    step("t2_start", ST, 0, 24'h100000, F_RUN);
    step("t2_tick", TK, 0, 24'h095959, F_RUN);

    // 3: load legality
    step("t3_pause", PS, 0, 24'h095959, F_PAU);
    step("t3_ld_24h", LD, 24'h240000,
         24'h095959, F_PAU | F_ERR);
    step("t3_ld_60m", LD, 24'h126000,
         24'h095959, F_PAU | F_ERR);
    step("t3_ld_max", LD, 24'h235959, 24'h235959, F_IDLE);
    step("t3_no_err", NO, 0, 24'h235959, F_IDLE);

    // 4: pause wins over start, ticks held in PAUSE
    step("t4_load", LD, 24'h000030, 24'h000030, F_IDLE);
    step("t4_start", ST, 0, 24'h000030, F_RUN);
    step("t4_ps_st", PS | ST, 0, 24'h000030, F_PAU);
    for (int i = 0; i < 5; i++)
      step("t4_tick_paused", TK, 0, 24'h000030, F_PAU);
    step("t4_resume_tick", ST | TK, 0, 24'h000030, F_RUN);
    step("t4_tick", TK, 0, 24'h000029, F_RUN);

    // 5: start at zero, load during RUN
    step("t5_clear", CL, 0, 24'h000000, F_IDLE);
    step("t5_start_zero", ST, 0, 24'h000000, F_IDLE);
    step("t5_load", LD, 24'h000005, 24'h000005, F_IDLE);
    step("t5_start", ST, 0, 24'h000005, F_RUN);
    step("t5_tick", TK, 0, 24'h000004, F_RUN);
    step("t5_ld_run", LD, 24'h000100,
         24'h000004, F_RUN | F_ERR);
    step("t5_tick2", TK, 0, 24'h000003, F_RUN);

    // 6: async reset mid-RUN, clear in DONE
    step("t6_pause", PS, 0, 24'h000003, F_PAU);
    step("t6_load", LD, 24'h054321, 24'h054321, F_IDLE);
    step("t6_start", ST, 0, 24'h054321, F_RUN);
    #2 rst = 1'b1;
    #1 expect_now("t6_async_rst", 24'h000000, F_IDLE);
    check();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step("t6_load1", LD, 24'h000001, 24'h000001, F_IDLE);
    step("t6_start", ST, 0, 24'h000001, F_RUN);
    step("t6_expire", TK, 0, 24'h000000, F_DONE);
    step("t6_clear", CL, 0, 24'h000000, F_IDLE);
    step("t6_after", NO, 0, 24'h000000, F_IDLE);
    step("t6_restart", ST, 0, 24'h000000, F_IDLE);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard leftover=%0d", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
